// File: rtl/sd_spi_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sd_spi_arbiter : shares the SD SPI pins between init, read and write engines.
// Optional engine timeouts via SD_SPI_ARB_TIMEOUT_EN.                 Rev 1.0
// ----------------------------------------------------------------------------
module sd_spi_arbiter #(
  parameter int START_HOLD     = 2,
  parameter int BUSY_WAIT      = 15,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic        clk_sd,
  input  logic        reset,
  input  logic        init_done,
  input  logic        init_cs,
  input  logic        init_mosi,
  input  logic        rd_cmd_valid,
  input  logic [31:0] rd_cmd_addr,
  output logic        rd_cmd_ready,
  input  logic        wr_cmd_valid,
  input  logic [31:0] wr_cmd_addr,
  output logic        wr_cmd_ready,
  output logic        rd_start_en,
  output logic        wr_start_en,
  output logic [31:0] rd_sec_addr,
  output logic [31:0] wr_sec_addr,
  input  logic        rd_busy,
  input  logic        wr_busy,
  input  logic        rd_cs,
  input  logic        rd_mosi,
  input  logic        wr_cs,
  input  logic        wr_mosi,
  output logic        sd_spi_cs,
  output logic        sd_spi_mosi,
  output logic [1:0]  grant,
  output logic        arb_busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

`ifdef SD_SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_WAIT);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(TIMEOUT_CYCLES);
`else
  localparam int MAX_SHORT = (START_HOLD > GAP_CYCLES) ? START_HOLD : GAP_CYCLES;
  localparam int CNT_W     = (MAX_SHORT < 2) ? 1 : $clog2(MAX_SHORT + 1);
`endif
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             last_wr;
  logic             pick_rd;
  logic             pick_wr;
  logic             sel_busy;
  logic             arb_ok;
`ifdef SD_SPI_ARB_TIMEOUT_EN
  logic             tmo;
`endif

  // Handshake is combinational so a request dropped before acceptance is never granted.
  assign arb_ok   = init_done && !reset;
  assign sel_busy = grant[1] ? wr_busy : rd_busy;

  always_comb begin
    next_state = state;
    pick_rd    = 1'b0;
    pick_wr    = 1'b0;
`ifdef SD_SPI_ARB_TIMEOUT_EN
    tmo        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (arb_ok) begin
          if (rd_cmd_valid && (!wr_cmd_valid || last_wr)) begin
            pick_rd = 1'b1;
          end else if (wr_cmd_valid) begin
            pick_wr = 1'b1;
          end
          if (pick_rd || pick_wr) begin
            next_state = START;
          end
        end
      end
      START: begin
        if (cnt == HOLD_LAST) begin
          next_state = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (sel_busy) begin
          next_state = WAIT_DONE;
`ifdef SD_SPI_ARB_TIMEOUT_EN
        end else if (cnt == BUSY_LAST) begin
          tmo        = 1'b1;
          next_state = GAP;
`endif
        end
      end
      WAIT_DONE: begin
        if (!sel_busy) begin
          next_state = GAP;
`ifdef SD_SPI_ARB_TIMEOUT_EN
        end else if (cnt == DONE_LAST) begin
          tmo        = 1'b1;
          next_state = GAP;
`endif
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // Losing the card mid-transaction abandons the engine and idles the pins.
    if (!init_done && (state != IDLE) && (state != GAP)) begin
      next_state = GAP;
    end
  end

  always_ff @(posedge clk_sd or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      grant       <= 2'b00;
      last_wr     <= 1'b1;
      rd_sec_addr <= '0;
      wr_sec_addr <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        cnt <= '0;
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
      if (pick_rd) begin
        grant       <= 2'b01;
        last_wr     <= 1'b0;
        rd_sec_addr <= rd_cmd_addr;
      end else if (pick_wr) begin
        grant       <= 2'b10;
        last_wr     <= 1'b1;
        wr_sec_addr <= wr_cmd_addr;
      end else if (next_state == GAP) begin
        grant <= 2'b00;
      end
    end
  end

  assign rd_cmd_ready = pick_rd;
  assign wr_cmd_ready = pick_wr;
  assign rd_start_en  = (state == START) && (grant == 2'b01) && init_done;
  assign wr_start_en  = (state == START) && (grant == 2'b10) && init_done;
  assign arb_busy     = (state != IDLE);

`ifdef SD_SPI_ARB_TIMEOUT_EN
  assign timeout_err = tmo;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    sd_spi_cs   = 1'b1;
    sd_spi_mosi = 1'b1;
    if (!init_done) begin
      sd_spi_cs   = init_cs;
      sd_spi_mosi = init_mosi;
    end else begin
      case (grant)
        2'b01: begin
          sd_spi_cs   = rd_cs;
          sd_spi_mosi = rd_mosi;
        end
        2'b10: begin
          sd_spi_cs   = wr_cs;
          sd_spi_mosi = wr_mosi;
        end
        default: begin
          sd_spi_cs   = 1'b1;
          sd_spi_mosi = 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_arbiter.sv
`default_nettype none
// tb_sd_spi_arbiter : directed self-checking bench for sd_spi_arbiter.
module tb_sd_spi_arbiter;

  logic        clk_sd;
  logic        reset;
  logic        init_done;
  logic        init_cs;
  logic        init_mosi;
  logic        rd_cmd_valid;
  logic [31:0] rd_cmd_addr;
  logic        rd_cmd_ready;
  logic        wr_cmd_valid;
  logic [31:0] wr_cmd_addr;
  logic        wr_cmd_ready;
  logic        rd_start_en;
  logic        wr_start_en;
  logic [31:0] rd_sec_addr;
  logic [31:0] wr_sec_addr;
  logic        rd_busy;
  logic        wr_busy;
  logic        rd_cs;
  logic        rd_mosi;
  logic        wr_cs;
  logic        wr_mosi;
  logic        sd_spi_cs;
  logic        sd_spi_mosi;
  logic [1:0]  grant;
  logic        arb_busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  sd_spi_arbiter dut (
    .clk_sd       (clk_sd),
    .reset        (reset),
    .init_done    (init_done),
    .init_cs      (init_cs),
    .init_mosi    (init_mosi),
    .rd_cmd_valid (rd_cmd_valid),
    .rd_cmd_addr  (rd_cmd_addr),
    .rd_cmd_ready (rd_cmd_ready),
    .wr_cmd_valid (wr_cmd_valid),
    .wr_cmd_addr  (wr_cmd_addr),
    .wr_cmd_ready (wr_cmd_ready),
    .rd_start_en  (rd_start_en),
    .wr_start_en  (wr_start_en),
    .rd_sec_addr  (rd_sec_addr),
    .wr_sec_addr  (wr_sec_addr),
    .rd_busy      (rd_busy),
    .wr_busy      (wr_busy),
    .rd_cs        (rd_cs),
    .rd_mosi      (rd_mosi),
    .wr_cs        (wr_cs),
    .wr_mosi      (wr_mosi),
    .sd_spi_cs    (sd_spi_cs),
    .sd_spi_mosi  (sd_spi_mosi),
    .grant        (grant),
    .arb_busy     (arb_busy),
    .timeout_err  (timeout_err)
  );

  initial clk_sd = 1'b0;
  always #5 clk_sd = ~clk_sd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs sampled 1 unit later.
  task automatic step();
    @(posedge clk_sd);
    #2;
  endtask

  // Expects to be called on the first GAP cycle; returns on the first IDLE cycle.
  task automatic gap_check(input string tag);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk({tag, "_gap_cs"}, sd_spi_cs, 1'b1);
      chk({tag, "_gap_mosi"}, sd_spi_mosi, 1'b1);
      chk({tag, "_gap_grant"}, grant, 2'b00);
      chk({tag, "_gap_busy"}, arb_busy, 1'b1);
      step();
    end
    #1;
    chk({tag, "_idle_busy"}, arb_busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; init_done = 1'b0; init_cs = 1'b1; init_mosi = 1'b1;
    rd_cmd_valid = 1'b0; rd_cmd_addr = '0; wr_cmd_valid = 1'b0; wr_cmd_addr = '0;
    rd_busy = 1'b0; wr_busy = 1'b0;
    rd_cs = 1'b1; rd_mosi = 1'b1; wr_cs = 1'b1; wr_mosi = 1'b1;
    repeat (3) step();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_arb_busy", arb_busy, 1'b0);
    chk("rst_rd_start", rd_start_en, 1'b0);
    chk("rst_wr_start", wr_start_en, 1'b0);
    chk("rst_rd_addr", rd_sec_addr, 32'h0);
    chk("rst_wr_addr", wr_sec_addr, 32'h0);
    chk("rst_timeout", timeout_err, 1'b0);
    step();
    reset = 1'b0;

    // Init engine owns the pins and requests wait while init_done is low.
    rd_cmd_valid = 1'b1;
    rd_cmd_addr  = 32'hA5A5_0001;
    for (int i = 0; i < 100; i++) begin
      init_cs   = i[0];
      init_mosi = i[1];
      #1;
      chk("t1_ready_held", rd_cmd_ready, 1'b0);
      chk("t1_init_cs", sd_spi_cs, i[0]);
      chk("t1_init_mosi", sd_spi_mosi, i[1]);
      step();
    end
    init_cs = 1'b1; init_mosi = 1'b1;
    init_done = 1'b1;
    #1;
    chk("t1_rd_ready", rd_cmd_ready, 1'b1);
    chk("t1_wr_ready", wr_cmd_ready, 1'b0);
    step();
    rd_cmd_valid = 1'b0;
    #1;
    chk("t1_ready_pulse", rd_cmd_ready, 1'b0);
    chk("t1_grant", grant, 2'b01);
    chk("t1_addr", rd_sec_addr, 32'hA5A5_0001);
    chk("t1_arb_busy", arb_busy, 1'b1);
    chk("t1_start1", rd_start_en, 1'b1);
    step();
    #1;
    chk("t1_start2", rd_start_en, 1'b1);
    step();
    rd_cs = 1'b0; rd_mosi = 1'b0;
    #1;
    chk("t1_start_off", rd_start_en, 1'b0);
    chk("t1_pin_cs", sd_spi_cs, 1'b0);
    chk("t1_pin_mosi", sd_spi_mosi, 1'b0);
`ifdef SD_SPI_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      chk("t1_no_tmo", timeout_err, 1'b0);
      step();
      #1;
    end
    chk("t1_tmo_pulse", timeout_err, 1'b1);
    chk("t1_tmo_grant", grant, 2'b01);
    step();
    #1;
    chk("t1_tmo_clear", timeout_err, 1'b0);
    chk("t1_tmo_gap_grant", grant, 2'b00);
    gap_check("t1");
`else
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      chk("t1_wait_busy", arb_busy, 1'b1);
      chk("t1_wait_grant", grant, 2'b01);
      chk("t1_no_tmo", timeout_err, 1'b0);
    end
    rd_busy = 1'b1;
    step();
    #1;
    chk("t1_done_grant", grant, 2'b01);
    rd_busy = 1'b0;
    step();
    gap_check("t1");
`endif
    rd_cs = 1'b1; rd_mosi = 1'b1;

    // Single write with a 3-cycle busy latency and 50-cycle busy.
    wr_cmd_addr  = 32'h0000_1234;
    wr_cmd_valid = 1'b1;
    #1;
    chk("t2_wr_ready", wr_cmd_ready, 1'b1);
    chk("t2_rd_ready", rd_cmd_ready, 1'b0);
    step();
    wr_cmd_valid = 1'b0;
    #1;
    chk("t2_ready_pulse", wr_cmd_ready, 1'b0);
    chk("t2_grant", grant, 2'b10);
    chk("t2_addr", wr_sec_addr, 32'h0000_1234);
    chk("t2_start1", wr_start_en, 1'b1);
    chk("t2_rd_start", rd_start_en, 1'b0);
    step();
    #1;
    chk("t2_start2", wr_start_en, 1'b1);
    step();
    #1;
    chk("t2_start_off", wr_start_en, 1'b0);
    step();
    wr_busy = 1'b1;
    wr_cs = 1'b0; wr_mosi = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      chk("t2_grant_hold", grant, 2'b10);
      chk("t2_pin_cs", sd_spi_cs, 1'b0);
      chk("t2_pin_mosi", sd_spi_mosi, 1'b0);
      chk("t2_no_start", wr_start_en, 1'b0);
      step();
    end
    wr_busy = 1'b0;
    step();
    gap_check("t2");
    wr_cs = 1'b1; wr_mosi = 1'b1;

    // Both requesters held: strict alternation starting with read (last was write).
    rd_cmd_valid = 1'b1;
    wr_cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic is_wr;
      is_wr = k[0];
      rd_cmd_addr = 32'h3000_0000 + k;
      wr_cmd_addr = 32'h4000_0000 + k;
      #1;
      chk("t3_rd_ready", rd_cmd_ready, !is_wr);
      chk("t3_wr_ready", wr_cmd_ready, is_wr);
      step();
      if (k == 3) begin
        rd_cmd_valid = 1'b0;
        wr_cmd_valid = 1'b0;
      end
      #1;
      chk("t3_ready_pulse", {rd_cmd_ready, wr_cmd_ready}, 2'b00);
      chk("t3_grant", grant, is_wr ? 2'b10 : 2'b01);
      if (is_wr) chk("t3_wr_addr", wr_sec_addr, 32'h4000_0000 + k);
      else       chk("t3_rd_addr", rd_sec_addr, 32'h3000_0000 + k);
      step();
      step();
      if (is_wr) wr_busy = 1'b1; else rd_busy = 1'b1;
      step();
      #1;
      chk("t3_done_busy", arb_busy, 1'b1);
      wr_busy = 1'b0; rd_busy = 1'b0;
      step();
      gap_check("t3");
    end

    // init_done drops during WAIT_DONE.
    rd_cmd_addr  = 32'h0000_5555;
    rd_cmd_valid = 1'b1;
    #1;
    chk("t4_rd_ready", rd_cmd_ready, 1'b1);
    step();
    rd_cmd_valid = 1'b0;
    step();
    step();
    rd_busy = 1'b1;
    step();
    #1;
    chk("t4_grant_pre", grant, 2'b01);
    init_cs = 1'b0; init_mosi = 1'b1; rd_cs = 1'b1; rd_mosi = 1'b0;
    init_done = 1'b0;
    rd_cmd_valid = 1'b1;
    #1;
    chk("t4_init_cs", sd_spi_cs, 1'b0);
    chk("t4_init_mosi", sd_spi_mosi, 1'b1);
    chk("t4_start", rd_start_en, 1'b0);
    step();
    rd_busy = 1'b0;
    #1;
    chk("t4_gap_grant", grant, 2'b00);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t4_gap_busy", arb_busy, 1'b1);
      chk("t4_no_ready", rd_cmd_ready, 1'b0);
      step();
    end
    #1;
    chk("t4_idle", arb_busy, 1'b0);
    chk("t4_idle_no_ready", rd_cmd_ready, 1'b0);
    step();
    #1;
    chk("t4_idle_stay", arb_busy, 1'b0);
    rd_cmd_valid = 1'b0;
    init_done = 1'b1; init_cs = 1'b1; init_mosi = 1'b1; rd_mosi = 1'b1;

    // Reset asserted during START.
    wr_cmd_addr  = 32'h0000_6666;
    wr_cmd_valid = 1'b1;
    #1;
    chk("t5_wr_ready", wr_cmd_ready, 1'b1);
    step();
    wr_cmd_valid = 1'b0;
    #1;
    chk("t5_start", wr_start_en, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_rst_start", wr_start_en, 1'b0);
    chk("t5_rst_grant", grant, 2'b00);
    chk("t5_rst_busy", arb_busy, 1'b0);
    chk("t5_rst_ready", wr_cmd_ready, 1'b0);
    chk("t5_rst_addr", wr_sec_addr, 32'h0);
    step();
    reset = 1'b0;
    rd_cmd_addr = 32'h0000_7777; wr_cmd_addr = 32'h0000_8888;
    rd_cmd_valid = 1'b1; wr_cmd_valid = 1'b1;
    #1;
    chk("t5_rd_first", rd_cmd_ready, 1'b1);
    chk("t5_wr_wait", wr_cmd_ready, 1'b0);
    step();
    rd_cmd_valid = 1'b0; wr_cmd_valid = 1'b0;
    #1;
    chk("t5_grant", grant, 2'b01);
    chk("t5_addr", rd_sec_addr, 32'h0000_7777);
    step();
    step();
    rd_busy = 1'b1;
    step();
    rd_busy = 1'b0;
    step();
    gap_check("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_spi_arbiter.md
Name: sd_spi_arbiter

Overview:
- Shares the single SD-card SPI port between the init engine, the sector-read engine and the sector-write engine.
- Accepts read/write sector commands from the user side.
- Starts the matching engine with a held start pulse and tracks that engine's busy signal to completion.
- Drives CS/MOSI from the selected engine and inserts a CS-high gap between transactions. MISO fans out to all engines directly and does not pass through this block.

Parameters:
- START_HOLD, 2: cycles the engine start enable is held high. The engines edge-detect their start input through 2 flops.
- BUSY_WAIT, 15: maximum cycles to wait for the engine busy to rise after start is released.
- GAP_CYCLES, 8: CS-high, MOSI-high idle cycles after each transaction.
- TIMEOUT_CYCLES, 1048575: maximum cycles engine busy may stay high (only used with the optional feature). Counter width is 20 bits.

Ports:
- clk_sd  in  1  SPI-domain clock. Everything is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- init_done  in  1  card initialised. Low means the init engine owns the pins.
- init_cs, init_mosi  in  1  init engine pin outputs.
- rd_cmd_valid  in  1  user read request.
- rd_cmd_addr  in  32  read sector address.
- rd_cmd_ready  out  1  read request accepted (1-cycle).
- wr_cmd_valid  in  1  user write request.
- wr_cmd_addr  in  32  write sector address.
- wr_cmd_ready  out  1  write request accepted (1-cycle).
- rd_start_en, wr_start_en  out  1  engine start enables.
- rd_sec_addr, wr_sec_addr  out  32  latched sector address to each engine.
- rd_busy, wr_busy  in  1  engine busy flags.
- rd_cs, rd_mosi, wr_cs, wr_mosi  in  1  engine pin outputs.
- sd_spi_cs, sd_spi_mosi  out  1  card pins.
- grant  out  2  00 none, 01 read, 10 write.
- arb_busy  out  1  high in every state except IDLE.
- timeout_err  out  1  1-cycle error pulse (optional feature only).

Behaviour:
- Reset values:
  - state=IDLE, grant=00, last=write (so read wins the first tie).
  - All start enables and ready outputs 0; addresses 0; arb_busy 0; timeout_err 0.
- Pin mux (combinational from registered grant):
  - init_done=0: pins = init_cs/init_mosi.
  - grant=01: pins = rd_cs/rd_mosi.
  - grant=10: pins = wr_cs/wr_mosi.
  - Otherwise cs=1, mosi=1.
  - grant changes only in IDLE or GAP, while the engine CS is high.
- States:
  - IDLE:
    - Requires init_done=1 to arbitrate.
    - If exactly one valid, grant it. If both valid, grant the one not equal to last.
    - On grant, for one cycle: assert the matching *_cmd_ready, latch the address into *_sec_addr, set grant and last, then go to START.
    - While init_done=0, ready is held low and valid requests wait.
  - START: drive the selected start_en=1 for START_HOLD cycles, then drive it 0 and go to WAIT_BUSY.
  - WAIT_BUSY: stay until the selected busy=1, then go to WAIT_DONE. Busy already high on entry is accepted immediately.
  - WAIT_DONE: stay until the selected busy=0, then go to GAP.
  - GAP:
    - grant=00, so pins idle high.
    - Count GAP_CYCLES, then go to IDLE.
    - A request may be granted on the first IDLE cycle after the gap, so back-to-back commands see exactly GAP_CYCLES cycles of CS high.
- Simultaneous read and write valid: strict alternation; neither side starves.
- Valid deasserted before ready: no grant. The valid/ready handshake completes only in the cycle where both are high.
- init_done falling in any non-IDLE state:
  - start enables go 0 at once, grant goes 00, then GAP, then IDLE.
  - Pins revert to the init engine immediately.
  - No ready is issued while init_done is low.
- Reset mid-transaction returns to reset values at once. Engines are reset by their own reset.
- Counters are saturating. They are cleared on every state entry.

Optional Feature:
- Macro SD_SPI_ARB_TIMEOUT_EN.
- Defined:
  - WAIT_BUSY exceeding BUSY_WAIT cycles, or WAIT_DONE exceeding TIMEOUT_CYCLES, pulses timeout_err for 1 cycle and forces GAP.
  - Engine pins are then masked (grant=00).
- Undefined:
  - WAIT_BUSY and WAIT_DONE wait indefinitely.
  - timeout_err is tied 0 and no timeout counter is built.

Test Plan:
- init_done=0, rd_cmd_valid=1 for 100 cycles -> rd_cmd_ready stays 0, pins follow init_cs/init_mosi. Raise init_done -> ready pulse within 1 cycle, rd_sec_addr = rd_cmd_addr.
- Single write, addr 32'h0000_1234, engine model raises busy 3 cycles after start and holds it 50 cycles -> wr_start_en high exactly 2 cycles, wr_sec_addr=32'h1234, grant=10 throughout, then 8 cycles cs=1 mosi=1, arb_busy falls.
- rd and wr valid together, held for 4 commands -> grant order read, write, read, write. Each ready is 1 cycle and each has an 8-cycle gap.
- init_done dropped during WAIT_DONE -> start=0, grant=00 next cycle, pins switch to init engine, GAP, then IDLE with no ready.
- Reset asserted mid-START -> start_en, grant, ready, arb_busy all 0 asynchronously; next request is served normally after release.
- With SD_SPI_ARB_TIMEOUT_EN, engine never raises busy -> timeout_err pulses at cycle 16 of WAIT_BUSY, grant=00, arbiter then returns to IDLE via an 8-cycle GAP. Without the macro, the arbiter stays in WAIT_BUSY.
